load_store_unit: RTL

//  RV32I data-memory access unit for the STRV32I core. Issues loads and stores on a

---
 rtl/load_store_unit_pkg.sv | 48 ++++
 rtl/load_store_unit_if.sv | 58 +++++
 rtl/load_store_unit_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the RV32I load/store unit: funct3 encodings, FSM
// state type, store byte-lane base masks and the request-legality helpers used
// when the execute stage hands over an access.
// No ports (package).
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-lane base masks, shifted up by the byte offset for SB/SH
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  // Reserved encodings: loads 011/110/111, stores anything above SW.
  function automatic logic f3_reserved(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_SW);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Size is encoded in funct3[1:0] for both loads and stores.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the execute-stage request, the data-memory valid/ready port and the
// result/status outputs of the load/store unit.
//   master : the load/store unit itself (drives dmem request and results)
//   slave  : the surroundings (execute stage, data memory, write-back mux)
// Signals:
//   req_valid_in/req_ready_out, is_store_in, funct3_in, addr_in, rs2_in
//   dmem_req_valid_out/dmem_req_ready_in, dmem_addr_out, dmem_we_out,
//   dmem_wmask_out, dmem_wdata_out, dmem_rsp_valid_in, dmem_rdata_in
//   load_output_out, load_valid_out, store_done_out, misaligned_out,
//   illegal_out, timeout_out, stall_out
// -----------------------------------------------------------------------------
interface load_store_unit_if;

  logic        req_valid_in;
  logic        req_ready_out;
  logic        is_store_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] rs2_in;

  logic        dmem_req_valid_out;
  logic        dmem_req_ready_in;
  logic [31:0] dmem_addr_out;
  logic        dmem_we_out;
  logic [3:0]  dmem_wmask_out;
  logic [31:0] dmem_wdata_out;
  logic        dmem_rsp_valid_in;
  logic [31:0] dmem_rdata_in;

  logic [31:0] load_output_out;
  logic        load_valid_out;
  logic        store_done_out;
  logic        misaligned_out;
  logic        illegal_out;
  logic        timeout_out;
  logic        stall_out;

  modport master (
    input  req_valid_in, is_store_in, funct3_in, addr_in, rs2_in,
    input  dmem_req_ready_in, dmem_rsp_valid_in, dmem_rdata_in,
    output req_ready_out,
    output dmem_req_valid_out, dmem_addr_out, dmem_we_out, dmem_wmask_out, dmem_wdata_out,
    output load_output_out, load_valid_out, store_done_out,
    output misaligned_out, illegal_out, timeout_out, stall_out
  );

  modport slave (
    output req_valid_in, is_store_in, funct3_in, addr_in, rs2_in,
    output dmem_req_ready_in, dmem_rsp_valid_in, dmem_rdata_in,
    input  req_ready_out,
    input  dmem_req_valid_out, dmem_addr_out, dmem_we_out, dmem_wmask_out, dmem_wdata_out,
    input  load_output_out, load_valid_out, store_done_out,
    input  misaligned_out, illegal_out, timeout_out, stall_out
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_store_unit_load_align
// Combinational load extraction: picks the addressed byte/half out of the read
// word and sign- or zero-extends it to 32 bits.
//   i_funct3 [2:0]  : load funct3 (LB/LH/LW/LBU/LHU)
//   i_lane   [1:0]  : address bits [1:0]
//   i_rdata  [31:0] : word returned by data memory
//   o_result [31:0] : extended load result
// -----------------------------------------------------------------------------
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_byte_sx;
  logic signed [31:0] w_half_sx;

  always_comb begin
    w_byte    = i_rdata[8*i_lane +: 8];
    w_half    = i_rdata[16*i_lane[1] +: 16];
    w_byte_sx = w_byte;
    w_half_sx = w_half;
    case (i_funct3)
      F3_LB:   o_result = w_byte_sx;
      F3_LH:   o_result = w_half_sx;
      F3_LBU:  o_result = {24'h000000, w_byte};
      F3_LHU:  o_result = {16'h0000, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I data-memory access unit. Accepts one load/store from the execute stage,
// rejects misaligned or reserved accesses, issues the access on a valid/ready
// memory port and returns the aligned, extended load result for write-back.
// stall_out freezes the pipeline while an access is in flight.
//   clk_in    : core clock
//   rst_n_in  : synchronous active-low reset
//   bus       : load_store_unit_if.master (request, dmem port, results)
// Parameter RSP_TIMEOUT: WAIT cycles allowed for a load response, 0 = never.
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  // Timeout fires when the last allowed WAIT cycle passes without a response.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (RSP_TIMEOUT == 0) ? '0 : CNT_W'(RSP_TIMEOUT - 1);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lane;

  logic             r_req_ready;
  logic             r_stall;
  logic             r_dmem_req_valid;
  logic [31:0]      r_dmem_addr;
  logic             r_dmem_we;
  logic [3:0]       r_dmem_wmask;
  logic [31:0]      r_dmem_wdata;
  logic [31:0]      r_load_output;
  logic             r_load_valid;
  logic             r_store_done;
  logic             r_misaligned;
  logic             r_illegal;
  logic             r_timeout;

  logic             w_illegal;
  logic             w_misaligned;
  logic [3:0]       w_wmask;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_result;

  assign w_illegal    = f3_reserved(bus.is_store_in, bus.funct3_in);
  assign w_misaligned = f3_misaligned(bus.funct3_in, bus.addr_in[1:0]);

  // Store lanes: data replicated across the word, mask selects the lanes.
  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (bus.is_store_in) begin
      case (bus.funct3_in)
        F3_SB: begin
          w_wmask = MASK_B << bus.addr_in[1:0];
          w_wdata = {4{bus.rs2_in[7:0]}};
        end
        F3_SH: begin
          w_wmask = MASK_H << bus.addr_in[1:0];
          w_wdata = {2{bus.rs2_in[15:0]}};
        end
        F3_SW: begin
          w_wmask = MASK_W;
          w_wdata = bus.rs2_in;
        end
        default: begin
          w_wmask = 4'b0000;
          w_wdata = 32'h0000_0000;
        end
      endcase
    end
  end

  load_store_unit_load_align u_load_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_lane),
    .i_rdata  (bus.dmem_rdata_in),
    .o_result (w_load_result)
  );

  // Access attributes only matter once an access is in flight.
  always_ff @(posedge clk_in) begin
    if (r_state == ST_IDLE && bus.req_valid_in) begin
      r_is_store <= bus.is_store_in;
      r_funct3   <= bus.funct3_in;
      r_lane     <= bus.addr_in[1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_req_ready      <= 1'b1;
      r_stall          <= 1'b0;
      r_dmem_req_valid <= 1'b0;
      r_dmem_addr      <= 32'h0000_0000;
      r_dmem_we        <= 1'b0;
      r_dmem_wmask     <= 4'b0000;
      r_dmem_wdata     <= 32'h0000_0000;
      r_load_output    <= 32'h0000_0000;
      r_load_valid     <= 1'b0;
      r_store_done     <= 1'b0;
      r_misaligned     <= 1'b0;
      r_illegal        <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_store_done <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_in) begin
            // Rejected accesses never reach the memory port.
            if (w_illegal) begin
              r_illegal <= 1'b1;
            end else if (w_misaligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_state          <= ST_REQ;
              r_req_ready      <= 1'b0;
              r_stall          <= 1'b1;
              r_dmem_req_valid <= 1'b1;
              r_dmem_addr      <= {bus.addr_in[31:2], 2'b00};
              r_dmem_we        <= bus.is_store_in;
              r_dmem_wmask     <= w_wmask;
              r_dmem_wdata     <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          if (bus.dmem_req_ready_in) begin
            r_dmem_req_valid <= 1'b0;
            if (r_is_store) begin
              r_state      <= ST_IDLE;
              r_req_ready  <= 1'b1;
              r_stall      <= 1'b0;
              r_store_done <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end
          end
        end
        ST_WAIT: begin
          // A response on the last allowed cycle still completes the load.
          if (bus.dmem_rsp_valid_in) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_stall       <= 1'b0;
            r_load_output <= w_load_result;
            r_load_valid  <= 1'b1;
          end else if (RSP_TIMEOUT != 0 && r_cnt == CNT_LAST) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_stall     <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_req_ready      <= 1'b1;
          r_stall          <= 1'b0;
          r_dmem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_out      = r_req_ready;
  assign bus.stall_out          = r_stall;
  assign bus.dmem_req_valid_out = r_dmem_req_valid;
  assign bus.dmem_addr_out      = r_dmem_addr;
  assign bus.dmem_we_out        = r_dmem_we;
  assign bus.dmem_wmask_out     = r_dmem_wmask;
  assign bus.dmem_wdata_out     = r_dmem_wdata;
  assign bus.load_output_out    = r_load_output;
  assign bus.load_valid_out     = r_load_valid;
  assign bus.store_done_out     = r_store_done;
  assign bus.misaligned_out     = r_misaligned;
  assign bus.illegal_out        = r_illegal;
  assign bus.timeout_out        = r_timeout;

endmodule
